// File: rtl/uart_rx_oversampler.sv
// uart_rx_oversampler: oversampling UART receive front end (8N1, LSB first).
// 2-flop synchroniser, 3-sample majority vote per bit, framing-error detect.
// Define UART_RX_PARITY_EN to build the 8E1 variant with parity checking.
module uart_rx_oversampler #(
   parameter int unsigned SAMPLE_RATIO = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sample_tick,
   input  logic       din,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy
);

   localparam int unsigned CW = $clog2(SAMPLE_RATIO);
   localparam int unsigned M  = SAMPLE_RATIO / 2;

   localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_RATIO - 1);
   localparam logic [CW-1:0] CNT_SA   = CW'(M - 1);
   localparam logic [CW-1:0] CNT_SB   = CW'(M);
   localparam logic [CW-1:0] CNT_DEC  = CW'(M + 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] STOP   = 3'd3;
   localparam logic [2:0] BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd5;
`endif

   logic          s1, ds;
   logic [2:0]    state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    idx, idx_n;
   logic [7:0]    sh, sh_n;
   logic          v0, v0_n, v1, v1_n;
   logic [7:0]    data_n;
   logic          valid_n, frame_err_n, busy_n;
   logic          maj_c;
`ifdef UART_RX_PARITY_EN
   logic          par_bad, par_bad_n;
   logic          parity_err_n;
`endif

   // Two-flop synchroniser for the asynchronous serial line
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1 <= 1'b1;
         ds <= 1'b1;
      end else begin
         s1 <= din;
         ds <= s1;
      end
   end

   // 2-of-3 vote over the samples at M-1, M and the current one at M+1
   assign maj_c = (v0 & v1) | (v0 & ds) | (v1 & ds);

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         sh        <= '0;
         v0        <= 1'b1;
         v1        <= 1'b1;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         idx       <= idx_n;
         sh        <= sh_n;
         v0        <= v0_n;
         v1        <= v1_n;
         data      <= data_n;
         valid     <= valid_n;
         frame_err <= frame_err_n;
         busy      <= busy_n;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity tracking and error flag registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         par_bad    <= par_bad_n;
         parity_err <= parity_err_n;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

   // Next-state and next-output logic; everything holds between sample ticks
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      idx_n       = idx;
      sh_n        = sh;
      v0_n        = v0;
      v1_n        = v1;
      data_n      = data;
      valid_n     = 1'b0;
      frame_err_n = 1'b0;
      busy_n      = busy;
`ifdef UART_RX_PARITY_EN
      par_bad_n    = par_bad;
      parity_err_n = 1'b0;
`endif
      if (sample_tick) begin
         cnt_n = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
         if (cnt == CNT_SA) v0_n = ds;
         if (cnt == CNT_SB) v1_n = ds;
         case (state)
            IDLE: begin
               cnt_n = '0;
               if (!ds) begin
                  cnt_n   = CW'(1);
                  busy_n  = 1'b1;
                  state_n = START;
               end
            end
            START: begin
               if (cnt == CNT_DEC && maj_c) begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  cnt_n   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_n = DATA;
                  idx_n   = '0;
               end
            end
            DATA: begin
               if (cnt == CNT_DEC) sh_n = {maj_c, sh[7:1]};
               if (cnt == CNT_LAST) begin
                  idx_n = idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                  if (idx == 3'd7) state_n = PARITY;
`else
                  if (idx == 3'd7) state_n = STOP;
`endif
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt == CNT_DEC) par_bad_n = ^{sh, maj_c};
               if (cnt == CNT_LAST) state_n = STOP;
            end
`endif
            STOP: begin
               if (cnt == CNT_DEC) begin
                  data_n = sh;
                  if (maj_c) begin
                     state_n = IDLE;
                     busy_n  = 1'b0;
                     cnt_n   = '0;
`ifdef UART_RX_PARITY_EN
                     valid_n      = !par_bad;
                     parity_err_n = par_bad;
`else
                     valid_n = 1'b1;
`endif
                  end else begin
                     state_n     = BREAK;
                     frame_err_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                     parity_err_n = par_bad;
`endif
                  end
               end
            end
            BREAK: begin
               if (ds) begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  cnt_n   = '0;
               end
            end
            default: begin
               state_n = IDLE;
               busy_n  = 1'b0;
               cnt_n   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Self-checking bench for uart_rx_oversampler (R = 16, tick every 4 clk).
// Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx_oversampler;

   localparam int unsigned R = 16;
`ifdef UART_RX_PARITY_EN
   localparam int LAT = 10 * 16 + 8 + 1;
`else
   localparam int LAT = 9 * 16 + 8 + 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sample_tick = 1'b0;
   logic       din = 1'b1;
   logic [7:0] data;
   logic       valid, frame_err, parity_err, busy;

   uart_rx_oversampler #(.SAMPLE_RATIO(R)) dut (
      .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .din(din),
      .data(data), .valid(valid), .frame_err(frame_err),
      .parity_err(parity_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(negedge clk) begin
      cyc = cyc + 1;
      sample_tick = (cyc % 4 == 0);
   end

   int tick_no = 0;
   always @(posedge clk) if (sample_tick) tick_no <= tick_no + 1;

   // Output monitor
   int n_valid = 0, n_ferr = 0, n_perr = 0, n_excl = 0;
   int v_tick = 0, pv_tick = 0, rise_tick = 0, fall_tick = 0;
   logic [7:0] v_data = '0, pv_data = '0;
   logic busy_q = 1'b0;
   always @(negedge clk) begin
      if (valid) begin
         n_valid = n_valid + 1;
         pv_tick = v_tick;  pv_data = v_data;
         v_tick  = tick_no; v_data  = data;
      end
      if (frame_err) n_ferr = n_ferr + 1;
      if (parity_err) n_perr = n_perr + 1;
      if (valid && (frame_err || parity_err)) n_excl = n_excl + 1;
      if (busy && !busy_q) rise_tick = tick_no;
      if (!busy && busy_q) fall_tick = tick_no;
      busy_q = busy;
   end

   int checks = 0, failures = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         failures = failures + 1;
         $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (!sample_tick) @(posedge clk);
      end
   endtask

   // One bit period; optionally invert the line on a single tick
   task automatic drive_bit(input logic b, input int glitch);
      @(negedge clk); din = b;
      if (glitch < 0) begin
         wait_ticks(R);
      end else begin
         wait_ticks(glitch);
         @(negedge clk); din = ~b;
         wait_ticks(1);
         @(negedge clk); din = b;
         wait_ticks(R - glitch - 1);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip,
                             input int gbit, output int t0);
      @(negedge clk); din = 1'b0;
      t0 = tick_no + 1;
      wait_ticks(R);
      for (int i = 0; i < 8; i++) drive_bit(d[i], (i == gbit) ? 8 : -1);
`ifdef UART_RX_PARITY_EN
      drive_bit((^d) ^ pflip, -1);
`else
      if (pflip) $display("note: parity flip ignored in 8N1 build");
`endif
      drive_bit(stop, -1);
   endtask

   typedef struct {
      logic [7:0] d;
      logic       stop;
      logic       pflip;
      logic [7:0] exp_data;
      int         exp_valid;
      int         exp_ferr;
      int         exp_perr;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int bv, bf, bp, t0, t1;
      vecs.push_back('{8'h55, 1'b1, 1'b0, 8'h55, 1, 0, 0});
      vecs.push_back('{8'hA3, 1'b0, 1'b0, 8'hA3, 0, 1, 0});
      vecs.push_back('{8'h0F, 1'b1, 1'b0, 8'h0F, 1, 0, 0});
      vecs.push_back('{8'hC6, 1'b1, 1'b0, 8'hC6, 1, 0, 0});
`ifdef UART_RX_PARITY_EN
      vecs.push_back('{8'h07, 1'b1, 1'b0, 8'h07, 1, 0, 0});
      vecs.push_back('{8'h07, 1'b1, 1'b1, 8'h07, 0, 0, 1});
      vecs.push_back('{8'h5A, 1'b0, 1'b1, 8'h5A, 0, 1, 1});
`endif

      // Reset state, held across several ticks
      wait_ticks(3);
      @(negedge clk);
      chk("rst_data", data, 0);
      chk("rst_valid", valid, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_perr", parity_err, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      wait_ticks(4);

      // Table-driven frames
      foreach (vecs[k]) begin
         bv = n_valid; bf = n_ferr; bp = n_perr;
         send_frame(vecs[k].d, vecs[k].stop, vecs[k].pflip, -1, t0);
         if (!vecs[k].stop) wait_ticks(20);
         @(negedge clk); din = 1'b1;
         wait_ticks(24);
         @(negedge clk);
         chk($sformatf("v%0d_valid", k), n_valid - bv, vecs[k].exp_valid);
         chk($sformatf("v%0d_ferr", k), n_ferr - bf, vecs[k].exp_ferr);
         chk($sformatf("v%0d_perr", k), n_perr - bp, vecs[k].exp_perr);
         chk($sformatf("v%0d_data", k), data, vecs[k].exp_data);
         chk($sformatf("v%0d_busy", k), busy, 0);
         if (vecs[k].exp_valid == 1) begin
            chk($sformatf("v%0d_latency", k), v_tick - t0, LAT);
            chk($sformatf("v%0d_busy_fall", k), fall_tick, v_tick);
         end
      end

      // Start-bit glitch: low for 4 ticks only
      bv = n_valid; bf = n_ferr; bp = n_perr;
      @(negedge clk); din = 1'b0;
      t0 = tick_no + 1;
      wait_ticks(4);
      @(negedge clk); din = 1'b1;
      wait_ticks(20);
      @(negedge clk);
      chk("glitch_pulses", (n_valid - bv) + (n_ferr - bf) + (n_perr - bp), 0);
      chk("glitch_busy_rise", rise_tick, t0);
      chk("glitch_busy_fall", fall_tick, t0 + 9);

      // Back-to-back frames
      bv = n_valid;
      send_frame(8'h00, 1'b1, 1'b0, -1, t0);
      send_frame(8'hFF, 1'b1, 1'b0, -1, t1);
      wait_ticks(20);
      @(negedge clk);
      chk("b2b_count", n_valid - bv, 2);
      chk("b2b_spacing", v_tick - pv_tick, 160);
      chk("b2b_first", pv_data, 8'h00);
      chk("b2b_second", v_data, 8'hFF);

      // Single-tick glitch inside data bit 2
      bv = n_valid; bf = n_ferr;
      send_frame(8'h3C, 1'b1, 1'b0, 2, t0);
      wait_ticks(20);
      @(negedge clk);
      chk("vote_valid", n_valid - bv, 1);
      chk("vote_ferr", n_ferr - bf, 0);
      chk("vote_data", data, 8'h3C);

      // Reset during bit 4 of 0x81, then a clean 0x81
      bv = n_valid; bf = n_ferr; bp = n_perr;
      @(negedge clk); din = 1'b0;
      wait_ticks(R);
      for (int i = 0; i < 4; i++) drive_bit(1'(8'h81 >> i), -1);
      @(negedge clk); din = 1'b0;
      wait_ticks(8);
      @(negedge clk); rst_n = 1'b0;
      wait_ticks(2);
      @(negedge clk);
      chk("midrst_data", data, 0);
      chk("midrst_busy", busy, 0);
      din = 1'b1;
      rst_n = 1'b1;
      wait_ticks(30);
      @(negedge clk);
      chk("midrst_pulses", (n_valid - bv) + (n_ferr - bf) + (n_perr - bp), 0);
      send_frame(8'h81, 1'b1, 1'b0, -1, t0);
      wait_ticks(20);
      @(negedge clk);
      chk("after_rst_valid", n_valid - bv, 1);
      chk("after_rst_data", data, 8'h81);
      chk("after_rst_latency", v_tick - t0, LAT);

      chk("exclusive", n_excl, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_rx_oversampler.md
# uart_rx_oversampler

Oversampling UART receive front end: deserialises the asynchronous `din` line into bytes using a shared sample-rate enable tick, with a 2-flop synchroniser, 3-sample majority voting and framing-error detection. It is the stage directly upstream of the loopback sender path: its `data`/`valid` pair feeds the transmit-data mux, and `busy` drives the receive-status LED. Frame format is 8N1, LSB first; even parity is optional.

## Interface
- `SAMPLE_RATIO`, default 16: sample ticks per bit. Must be even and ≥ 8.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `sample_tick`, input, 1: one-`clk`-wide enable pulse at `SAMPLE_RATIO` × baud.
- `din`, input, 1: serial line. Idles high.
- `data`, output, 8: last received byte. Holds its value until the next frame completes.
- `valid`, output, 1: one-`clk` pulse when a good frame completes.
- `frame_err`, output, 1: one-`clk` pulse when the stop bit is sampled low.
- `parity_err`, output, 1: one-`clk` pulse on a parity mismatch. Tied to 0 when parity is compiled out.
- `busy`, output, 1: high from start detection until the FSM re-enters IDLE.

## Operation
- **Synchroniser.** `din` passes through 2 flops, both reset to 1. All FSM decisions use the synchronised value `ds`.
- **Tick counting.**
  - `cnt` counts `sample_tick` pulses within a bit, wrapping `R-1` → 0, where `R = SAMPLE_RATIO` and `M = R/2`.
  - All state changes happen only in cycles where `sample_tick` = 1. Between ticks the FSM holds.
- **Majority sampling.** Each bit is sampled at `cnt` = M-1, M and M+1. The bit value is the 2-of-3 majority, decided at `cnt` = M+1.
- **States.**
  - IDLE: on a tick with `ds` = 0, set `cnt` = 1, `busy` = 1, go to START. That tick counts as tick 0 of the start bit.
  - START: if the majority is 1 (glitch), go to IDLE and clear `busy`; no outputs pulse. Otherwise continue, and at `cnt` = R-1 go to DATA with bit index 0.
  - DATA: shift the majority into the shift register LSB-first. After bit 7 completes at `cnt` = R-1, go to PARITY if enabled, else STOP.
  - PARITY: compute the even-parity check over 8 data bits plus the parity bit. At `cnt` = R-1 go to STOP.
  - STOP: decide at `cnt` = M+1. Do not wait for the end of the bit; this allows resync on back-to-back frames.
    - Majority 1, no parity error: load `data`, pulse `valid`, go to IDLE.
    - Majority 1, parity error: load `data`, pulse `parity_err`, no `valid`, go to IDLE.
    - Majority 0: load `data`, pulse `frame_err` (and `parity_err` if it also mismatched), no `valid`, go to BREAK.
  - BREAK: wait for a tick with `ds` = 1, then go to IDLE. `busy` stays high throughout BREAK.
- **Exclusivity.** `valid` and either error flag never assert in the same cycle.

## Timing
- **Reset values.** `data` = 0x00, `valid` = 0, `frame_err` = 0, `parity_err` = 0, `busy` = 0, FSM = IDLE, `cnt` = 0, synchroniser = 11.
- **Reset precedence.** `rst_n` low overrides `sample_tick` in the same cycle.
- **Reset mid-frame.** The frame is aborted with no pulses, and `data` returns to 0x00.
- **Start latency.** A `din` falling edge is visible to the FSM 2 `clk` later. It is detected at the first `sample_tick` after that.
- **Output latency.** Counted from the detecting tick, at `cnt` = M+1 of the stop bit:
  - Without parity: 9·R + M + 1 ticks.
  - With parity: 10·R + M + 1 ticks.
- **Output registration.** `valid`, the error flags and `data` update on the `clk` edge of that deciding tick. Each flag is high for exactly that one `clk`.
- **Back-to-back frames.** A start bit immediately following a 1-bit stop must be detected.
- **Steady `din` = 0.** Produces one `frame_err`, then the FSM stays in BREAK with no further pulses.

## Configuration
- **`UART_RX_PARITY_EN` defined:** the PARITY state is present; the frame is 8E1 and `parity_err` is active.
- **`UART_RX_PARITY_EN` undefined:** the PARITY state and logic are absent; the frame is 8N1 and `parity_err` is constant 0.

## Test plan
All scenarios use R = 16, with `sample_tick` every 4 `clk` unless noted.
- Frame 0x55, 1 stop bit → `data` = 0x55, one `valid` pulse at 9·16+9 ticks after detection; no error pulses; `busy` falls in the same cycle.
- `din` low for 4 ticks, then high → no `valid` or error pulse; `busy` high, then back to 0 at the start-bit midpoint.
- Frame 0xA3 with stop bit 0, line held low 20 ticks, then frame 0x0F → `frame_err` pulse, `data` = 0xA3, no `valid`; then `data` = 0x0F with `valid`.
- Back-to-back 0x00 then 0xFF, each with 1 stop bit → two `valid` pulses, 160 ticks apart, `data` 0x00 then 0xFF.
- Frame 0x3C with bit 2 inverted on tick 8 only → majority recovers it; `data` = 0x3C, `valid`.
- `rst_n` low during bit 4 of 0x81, then a clean 0x81 → no pulse from the aborted frame, then `valid` with 0x81.
- Parity build only: 0x07 with parity bit 1 → `valid`. With parity bit 0 → `parity_err`, `data` = 0x07, no `valid`.
